// File: rtl/spdif_rx.sv
// S/P DIF (IEC 60958 consumer) receiver: oversampled biphase-mark decode with
// pulse-width classification, B/M/W preamble match and 24-bit sample output.
module spdif_rx #(
    parameter int unsigned HALF_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spdif_in,
    output logic [23:0] sample,
    output logic        channel,
    output logic        block_start,
    output logic        v_bit,
    output logic        u_bit,
    output logic        c_bit,
    output logic        parity_err,
    output logic        sample_valid,
    output logic        code_err,
    output logic        locked
);
    localparam int unsigned CW = $clog2(4 * HALF_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(4 * HALF_CYCLES);
    localparam logic [CW-1:0] T_S = CW'(HALF_CYCLES / 2);
    localparam logic [CW-1:0] T_M = CW'((3 * HALF_CYCLES) / 2);
    localparam logic [CW-1:0] T_L = CW'((5 * HALF_CYCLES) / 2);
    localparam logic [CW-1:0] T_G = CW'((7 * HALF_CYCLES) / 2);

    typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
    typedef enum logic [1:0] {P_GLITCH, P_S, P_M, P_L} pulse_t;

    logic          sync1, sync2, sync3, edge_det, edge_q;
    logic [CW-1:0] width;
    pulse_t        cls, cls_q;

    state_t        state, state_nxt;
    logic [1:0]    pre_idx, pre_idx_nxt;
    pulse_t        pre_p1, pre_p1_nxt;
    logic          ch_pend, ch_pend_nxt, blk_pend, blk_pend_nxt;
    logic [4:0]    slot, slot_nxt;
    logic          half_pend, half_pend_nxt;
    logic [26:0]   shreg, shreg_nxt;
    logic          par, par_nxt;
    logic [1:0]    good_cnt, good_cnt_nxt;
    logic          locked_nxt, strobe, err, match, bit_ok, bit_val;

    assign edge_det = sync2 ^ sync3;

    always_comb begin
        cls = P_GLITCH;
        if (width >= T_S && width < T_M)      cls = P_S;
        else if (width >= T_M && width < T_L) cls = P_M;
        else if (width >= T_L && width < T_G) cls = P_L;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            width  <= '0;
            edge_q <= 1'b0;
            cls_q  <= P_GLITCH;
        end else begin
            sync1  <= spdif_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= edge_det;
            cls_q  <= cls;
            if (edge_det)         width <= CW'(1);
            else if (width < SAT) width <= width + CW'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        pre_idx_nxt   = pre_idx;
        pre_p1_nxt    = pre_p1;
        ch_pend_nxt   = ch_pend;
        blk_pend_nxt  = blk_pend;
        slot_nxt      = slot;
        half_pend_nxt = half_pend;
        shreg_nxt     = shreg;
        par_nxt       = par;
        strobe        = 1'b0;
        err           = 1'b0;
        match         = 1'b0;
        bit_ok        = 1'b0;
        bit_val       = 1'b0;
        if (edge_q) begin
            case (state)
                HUNT: if (cls_q == P_L) begin
                    state_nxt   = PRE;
                    pre_idx_nxt = 2'd1;
                end
                PRE: begin
                    // Second pulse selects the candidate preamble; the last one confirms it.
                    case (pre_idx)
                        2'd0:    match = (cls_q == P_L);
                        2'd1:    match = (cls_q != P_GLITCH);
                        2'd2:    match = (cls_q == P_S);
                        default: match = (pre_p1 == P_S && cls_q == P_L) ||
                                         (pre_p1 == P_L && cls_q == P_S) ||
                                         (pre_p1 == P_M && cls_q == P_M);
                    endcase
                    if (!match) begin
                        err = 1'b1;
                        if (cls_q == P_L) pre_idx_nxt = 2'd1;
                        else              state_nxt   = HUNT;
                    end else if (pre_idx == 2'd3) begin
                        state_nxt     = DATA;
                        slot_nxt      = 5'd4;
                        half_pend_nxt = 1'b0;
                        par_nxt       = 1'b0;
                        ch_pend_nxt   = (pre_p1 == P_M);
                        blk_pend_nxt  = (pre_p1 == P_S);
                    end else begin
                        pre_idx_nxt = pre_idx + 2'd1;
                        if (pre_idx == 2'd1) pre_p1_nxt = cls_q;
                    end
                end
                DATA: begin
                    case (cls_q)
                        P_S: begin
                            half_pend_nxt = ~half_pend;
                            bit_ok        = half_pend;
                            bit_val       = 1'b1;
                        end
                        P_M: begin
                            if (half_pend) begin
                                err       = 1'b1;
                                state_nxt = HUNT;
                            end else begin
                                bit_ok = 1'b1;
                            end
                        end
                        P_L: begin
                            err         = 1'b1;
                            state_nxt   = PRE;
                            pre_idx_nxt = 2'd1;
                        end
                        default: begin
                            err       = 1'b1;
                            state_nxt = HUNT;
                        end
                    endcase
                end
                default: state_nxt = HUNT;
            endcase
            // Slot 31 (parity) is never shifted: it only closes the accumulator.
            if (bit_ok) begin
                par_nxt  = par ^ bit_val;
                slot_nxt = slot + 5'd1;
                if (slot == 5'd31) begin
                    strobe      = 1'b1;
                    state_nxt   = PRE;
                    pre_idx_nxt = 2'd0;
                end else begin
                    shreg_nxt = {bit_val, shreg[26:1]};
                end
            end
        end
    end

    always_comb begin
        good_cnt_nxt = good_cnt;
        locked_nxt   = locked;
        if (err || (strobe && par_nxt)) begin
            good_cnt_nxt = 2'd0;
            locked_nxt   = 1'b0;
        end else if (strobe) begin
            if (good_cnt != 2'd3) good_cnt_nxt = good_cnt + 2'd1;
            if (good_cnt_nxt >= 2'd2) locked_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            pre_idx      <= 2'd0;
            pre_p1       <= P_GLITCH;
            ch_pend      <= 1'b0;
            blk_pend     <= 1'b0;
            slot         <= '0;
            half_pend    <= 1'b0;
            shreg        <= '0;
            par          <= 1'b0;
            good_cnt     <= 2'd0;
            locked       <= 1'b0;
            sample       <= '0;
            channel      <= 1'b0;
            block_start  <= 1'b0;
            v_bit        <= 1'b0;
            u_bit        <= 1'b0;
            c_bit        <= 1'b0;
            parity_err   <= 1'b0;
            sample_valid <= 1'b0;
            code_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            pre_idx      <= pre_idx_nxt;
            pre_p1       <= pre_p1_nxt;
            ch_pend      <= ch_pend_nxt;
            blk_pend     <= blk_pend_nxt;
            slot         <= slot_nxt;
            half_pend    <= half_pend_nxt;
            shreg        <= shreg_nxt;
            par          <= par_nxt;
            good_cnt     <= good_cnt_nxt;
            locked       <= locked_nxt;
            sample_valid <= strobe;
            code_err     <= err;
            if (strobe) begin
                sample      <= shreg[23:0];
                v_bit       <= shreg[24];
                u_bit       <= shreg[25];
                c_bit       <= shreg[26];
                channel     <= ch_pend;
                block_start <= blk_pend;
                parity_err  <= par_nxt;
            end
        end
    end
endmodule

// File: tb/tb_spdif_rx.sv
// Directed bench for spdif_rx: drives BMC pulse trains and checks each strobe
// against a queue of expected subframes and code-error times.
`timescale 1ns/1ps
module tb_spdif_rx;
    localparam int unsigned H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spdif_in = 1'b0;
    logic [23:0] sample;
    logic        channel, block_start, v_bit, u_bit, c_bit;
    logic        parity_err, sample_valid, code_err, locked;

    spdif_rx #(.HALF_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .spdif_in(spdif_in),
        .sample(sample), .channel(channel), .block_start(block_start),
        .v_bit(v_bit), .u_bit(u_bit), .c_bit(c_bit),
        .parity_err(parity_err), .sample_valid(sample_valid),
        .code_err(code_err), .locked(locked)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] smp;
        logic ch, blk, v, u, c, pe, lk;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned ce_q[$];
    exp_t        pend_rec;
    bit          pend_sv = 1'b0, pend_ce = 1'b0;
    int          checks = 0, failures = 0;
    int unsigned sv_seen = 0, ce_seen = 0;
    int unsigned good = 0;
    logic        exp_lk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int unsigned t;
        #1;
        if (rst_n && (sample_valid || code_err))
            chk("sv_ce_exclusive", {31'b0, sample_valid & code_err}, 32'd0);
        if (rst_n && sample_valid) begin
            sv_seen++;
            chk("sv_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sv_cycle", cyc, e.at);
                chk("sample", {8'b0, sample}, {8'b0, e.smp});
                chk("channel", {31'b0, channel}, {31'b0, e.ch});
                chk("block_start", {31'b0, block_start}, {31'b0, e.blk});
                chk("vuc", {29'b0, v_bit, u_bit, c_bit}, {29'b0, e.v, e.u, e.c});
                chk("parity_err", {31'b0, parity_err}, {31'b0, e.pe});
                chk("locked", {31'b0, locked}, {31'b0, e.lk});
            end
        end
        if (rst_n && code_err) begin
            ce_seen++;
            chk("ce_expected", {31'b0, ce_q.size() > 0}, 32'd1);
            if (ce_q.size() > 0) begin
                t = ce_q.pop_front();
                chk("ce_cycle", cyc, t);
                chk("ce_locked_clear", {31'b0, locked}, 32'd0);
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Toggle the line, arming any expectation that this edge completes, then hold w cycles.
    task automatic tog(input int unsigned w);
        spdif_in = ~spdif_in;
        if (pend_sv) begin
            pend_rec.at = cyc + 4;
            exp_q.push_back(pend_rec);
            pend_sv = 1'b0;
        end
        if (pend_ce) begin
            ce_q.push_back(cyc + 4);
            pend_ce = 1'b0;
        end
        repeat (w) @(posedge clk);
        #1;
    endtask

    task automatic send_pre(input int k);
        case (k)
            0:       begin tog(3*H); tog(H);   tog(H); tog(3*H); end
            1:       begin tog(3*H); tog(3*H); tog(H); tog(H);   end
            default: begin tog(3*H); tog(2*H); tog(H); tog(2*H); end
        endcase
    endtask

    task automatic send_bits(input logic [27:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (w[i]) begin tog(H); tog(H); end
            else tog(2*H);
        end
    endtask

    function automatic logic [27:0] mk_word(input logic [23:0] s, input logic v, input logic u,
                                            input logic c, input logic flip);
        logic [27:0] w;
        w[26:0] = {c, u, v, s};
        w[27]   = (^w[26:0]) ^ flip;
        return w;
    endfunction

    task automatic err_model();
        good   = 0;
        exp_lk = 1'b0;
    endtask

    task automatic arm_sv(input logic [27:0] w, input int k);
        pend_rec.smp = w[23:0];
        pend_rec.v   = w[24];
        pend_rec.u   = w[25];
        pend_rec.c   = w[26];
        pend_rec.ch  = (k == 2);
        pend_rec.blk = (k == 0);
        pend_rec.pe  = ^w;
        if (pend_rec.pe) err_model();
        else begin
            if (good < 3) good++;
            exp_lk = (good >= 2);
        end
        pend_rec.lk = exp_lk;
        pend_sv = 1'b1;
    endtask

    task automatic send_sf(input int k, input logic [23:0] s, input logic v, input logic u,
                           input logic c, input logic flip);
        logic [27:0] w;
        w = mk_word(s, v, u, c, flip);
        send_pre(k);
        send_bits(w, 0, 27);
        arm_sv(w, k);
    endtask

    task automatic finish_scn(input string tag);
        tog(12);
        idle(8);
        chk({tag, "_sv_drained"}, exp_q.size(), 32'd0);
        chk({tag, "_ce_drained"}, ce_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(40);
        err_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample"}, {8'b0, sample}, 32'd0);
        chk({tag, "_flags"}, {23'b0, channel, block_start, v_bit, u_bit, c_bit,
                              parity_err, sample_valid, code_err, locked}, 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] w, w2;

        idle(3);
        chk_zero("reset");
        rst_n = 1'b1;
        idle(40);

        // Clean B subframe.
        send_sf(0, 24'h00A5F0, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_scn("single_b");
        idle(20);
        chk("hold_sample", {8'b0, sample}, 32'h00A5F0);

        do_reset();
        send_sf(0, 24'h111111, 1'b0, 1'b0, 1'b1, 1'b0);
        send_sf(2, 24'h222222, 1'b1, 1'b0, 1'b0, 1'b0);
        send_sf(1, 24'h333333, 1'b0, 1'b1, 1'b1, 1'b0);
        send_sf(2, 24'h800001, 1'b1, 1'b1, 1'b1, 1'b0);
        send_sf(1, 24'h7FFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_scn("stream");

        do_reset();
        send_sf(0, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
        send_sf(2, 24'h654321, 1'b0, 1'b1, 1'b0, 1'b0);
        send_sf(1, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b1);
        send_sf(2, 24'hFEDCBA, 1'b0, 1'b0, 1'b1, 1'b0);
        send_sf(1, 24'h0F1E2D, 1'b1, 1'b1, 1'b0, 1'b0);
        finish_scn("parity");

        // Threshold widths 20/4/11/27 in the preamble, 12/19 and 4+11 in the data.
        do_reset();
        w = mk_word(24'h005A3C, 1'b1, 1'b0, 1'b1, 1'b0);
        tog(20); tog(4); tog(11); tog(27);
        tog(12); tog(19); tog(4); tog(11);
        send_bits(w, 3, 27);
        arm_sv(w, 0);
        w2 = mk_word(24'h0C0C0C, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pre(1);
        send_bits(w2, 0, 5);
        tog(28);
        pend_ce = 1'b1;
        err_model();
        send_pre(0);
        send_bits(w2, 0, 9);
        tog(3);
        pend_ce = 1'b1;
        err_model();
        send_sf(2, 24'hBEEF01, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_scn("thresh");

        // Early M preamble interrupts a B subframe at slot 15.
        do_reset();
        w = mk_word(24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pre(0);
        send_bits(w, 0, 10);
        tog(3*H);
        pend_ce = 1'b1;
        err_model();
        tog(3*H); tog(H); tog(H);
        w2 = mk_word(24'h5500AA, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(w2, 0, 27);
        arm_sv(w2, 1);
        finish_scn("early_pre");

        // Idle line after a strobe: the next edge is a saturated GLITCH in PRE.
        idle(30);
        pend_ce = 1'b1;
        err_model();
        w = mk_word(24'h999999, 1'b1, 1'b1, 1'b1, 1'b0);
        send_pre(0);
        send_bits(w, 0, 16);
        rst_n = 1'b0;
        idle(2);
        chk_zero("midreset");
        chk("midreset_ce_drained", ce_q.size(), 32'd0);
        rst_n = 1'b1;
        idle(40);
        err_model();
        send_sf(0, 24'hC0FFEE, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_scn("after_reset");

        chk("total_sv", sv_seen, 32'd15);
        chk("total_ce", ce_seen, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
